// File: rtl/io_bus_router.sv
// Slot-bus router: decodes each accepted upstream transaction against per-channel
// address windows, forwards it over a valid/ready handshake and returns read data.
module io_bus_router #(
  parameter int                           CHANNELS      = 2,
  parameter int                           ADDR_W        = 3,
  parameter logic [CHANNELS*ADDR_W-1:0]   CH_BASE       = '0,
  parameter logic [CHANNELS*ADDR_W-1:0]   CH_MASK       = '1,
  parameter logic [CHANNELS-1:0]          CH_IOREQ      = '1,
  parameter int                           TIMEOUT       = 255,
  parameter logic [7:0]                   DEFAULT_RDATA = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     bus_address,
  input  logic                  bus_ioreq,
  input  logic                  bus_write,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [7:0]            bus_wdata,
  output logic [7:0]            bus_rdata,
  output logic                  bus_rdata_en,
  output logic [CHANNELS-1:0]   ch_valid,
  input  logic [CHANNELS-1:0]   ch_ready,
  output logic [ADDR_W-1:0]     ch_address,
  output logic                  ch_ioreq,
  output logic                  ch_write,
  output logic [7:0]            ch_wdata,
  input  logic [CHANNELS*8-1:0] ch_rdata,
  input  logic [CHANNELS-1:0]   ch_rdata_en,
  output logic                  timeout_flag,
  output logic                  busy
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, FWD, WAIT_RD} state_t;

  state_t              state_reg;
  logic [CHANNELS-1:0] ch_valid_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   address_reg;
  logic                ioreq_reg;
  logic                write_reg;
  logic [7:0]          wdata_reg;
  logic [7:0]          rdata_reg;
  logic                rdata_en_reg;
  logic                timeout_flag_reg;

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] hit_lowest;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ready;
  logic                sel_rdata_en;
  logic [7:0]          sel_rdata;
  logic                timeout_hit;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_decode
      assign hit[gi] =
        ((bus_address & CH_MASK[gi*ADDR_W +: ADDR_W]) ==
         (CH_BASE[gi*ADDR_W +: ADDR_W] & CH_MASK[gi*ADDR_W +: ADDR_W])) &&
        (bus_ioreq == CH_IOREQ[gi]);
    end
  endgenerate

  // Lowest-index hit wins when windows overlap.
  assign hit_lowest = hit & (~hit + CHANNELS'(1));

  always_comb begin
    hit_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = SEL_W'(i);
    end
  end

  always_comb begin
    sel_ready    = 1'b0;
    sel_rdata_en = 1'b0;
    sel_rdata    = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_reg == SEL_W'(i)) begin
        sel_ready    = ch_ready[i];
        sel_rdata_en = ch_rdata_en[i];
        sel_rdata    = ch_rdata[i*8 +: 8];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ch_valid_reg     <= '0;
      sel_reg          <= '0;
      cnt_reg          <= '0;
      address_reg      <= '0;
      ioreq_reg        <= 1'b0;
      write_reg        <= 1'b0;
      wdata_reg        <= 8'h00;
      rdata_reg        <= 8'hFF;
      rdata_en_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      rdata_en_reg     <= 1'b0;
      timeout_flag_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus_valid) begin
            address_reg <= bus_address;
            ioreq_reg   <= bus_ioreq;
            write_reg   <= bus_write;
            wdata_reg   <= bus_wdata;
            sel_reg     <= hit_idx;
            cnt_reg     <= '0;
            if (|hit) begin
              ch_valid_reg <= hit_lowest;
              state_reg    <= FWD;
            end else if (!bus_write) begin
              rdata_reg    <= DEFAULT_RDATA;
              rdata_en_reg <= 1'b1;
            end
          end
        end
        FWD: begin
          if (sel_ready && write_reg) begin
            ch_valid_reg <= '0;
            state_reg    <= IDLE;
          end else if (sel_ready && sel_rdata_en) begin
            ch_valid_reg <= '0;
            rdata_reg    <= sel_rdata;
            rdata_en_reg <= 1'b1;
            state_reg    <= IDLE;
          end else if (timeout_hit) begin
            ch_valid_reg     <= '0;
            timeout_flag_reg <= 1'b1;
            if (!write_reg) begin
              rdata_reg    <= DEFAULT_RDATA;
              rdata_en_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (sel_ready) begin
              ch_valid_reg <= '0;
              state_reg    <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (sel_rdata_en) begin
            rdata_reg    <= sel_rdata;
            rdata_en_reg <= 1'b1;
            state_reg    <= IDLE;
          end else if (timeout_hit) begin
            timeout_flag_reg <= 1'b1;
            rdata_reg        <= DEFAULT_RDATA;
            rdata_en_reg     <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          ch_valid_reg <= '0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus_ready    = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign bus_rdata    = rdata_reg;
  assign bus_rdata_en = rdata_en_reg;
  assign ch_valid     = ch_valid_reg;
  assign ch_address   = address_reg;
  assign ch_ioreq     = ioreq_reg;
  assign ch_write     = write_reg;
  assign ch_wdata     = wdata_reg;
  assign timeout_flag = timeout_flag_reg;

endmodule
